// File: rtl/dest_drain_rr.sv
// Purpose : drains the D0/D1 destination FIFOs round-robin, checks each word's dest bit, merges into one stream.
// Latency : rd in cycle N, word captured end of N+1, out_valid in N+2; one word/cycle sustained.
// Backpr. : credit (occ + pend - pop < 2) stops reads once the 2-entry output buffer would overflow; no word lost.
// Ports   : clk/reset_L/init control; D*_empty, D*_data_out from FIFOs; D*_rd read strobes (combinational);
//           out_data/out_valid/out_src/out_ready merged stream; count_D*, error_dest, idle_out status (registered).
module dest_drain_rr #(
    parameter int BW = 6,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          init,
    input  logic          D0_empty,
    input  logic          D1_empty,
    input  logic [BW-1:0] D0_data_out,
    input  logic [BW-1:0] D1_data_out,
    input  logic          out_ready,
    output logic          D0_rd,
    output logic          D1_rd,
    output logic [BW-1:0] out_data,
    output logic          out_valid,
    output logic          out_src,
    output logic [CW-1:0] count_D0,
    output logic [CW-1:0] count_D1,
    output logic          error_dest,
    output logic          idle_out
);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_ERROR} state_t;

    state_t        state_q, state_d;
    logic [1:0]    occ_q, occ_d;
    logic [BW-1:0] head_dat_q, head_dat_d, tail_dat_q, tail_dat_d;
    logic          head_src_q, head_src_d, tail_src_q, tail_src_d;
    logic          pend_q, pend_src_q;
    logic          last_q, last_d;          // 1 = D1 was granted last
    logic [CW-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic          err_q, err_d;

    logic          pop, credit_ok, can_read, grant1;
    logic [BW-1:0] cap_dat;
    logic          cap_ok, push, mismatch;

    // ---------------- read issue (combinational) ----------------
    assign pop       = (occ_q != 2'd0) && out_ready;
    // occ + pend - pop < 2, rearranged to avoid a negative intermediate
    assign credit_ok = ({1'b0, occ_q} + {2'b00, pend_q}) < (3'd2 + {2'b00, pop});
    assign can_read  = (state_q != S_ERROR) && credit_ok;

    always_comb begin
        grant1 = 1'b0;
        if (!D0_empty && !D1_empty) grant1 = ~last_q;
        else                        grant1 = D0_empty;
    end

    assign D0_rd = can_read && !D0_empty && !grant1;
    assign D1_rd = can_read && !D1_empty &&  grant1;

    // ---------------- capture / check ----------------
    assign cap_dat  = pend_src_q ? D1_data_out : D0_data_out;
    assign cap_ok   = (cap_dat[BW-2] == pend_src_q);
    assign push     = pend_q && cap_ok;
    assign mismatch = pend_q && !cap_ok;

    // ---------------- output buffer next state ----------------
    always_comb begin
        occ_d      = occ_q;
        head_dat_d = head_dat_q;
        head_src_d = head_src_q;
        tail_dat_d = tail_dat_q;
        tail_src_d = tail_src_q;
        case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_dat_d = cap_dat;
                    head_src_d = pend_src_q;
                end else begin
                    tail_dat_d = cap_dat;
                    tail_src_d = pend_src_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_dat_d = tail_dat_q;
                    head_src_d = tail_src_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // occupancy unchanged; new word lands behind whatever remains
                if (occ_q == 2'd1) begin
                    head_dat_d = cap_dat;
                    head_src_d = pend_src_q;
                end else begin
                    head_dat_d = tail_dat_q;
                    head_src_d = tail_src_q;
                    tail_dat_d = cap_dat;
                    tail_src_d = pend_src_q;
                end
            end
            default: ;
        endcase
    end

    // ---------------- counters, error flag, RR pointer ----------------
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        err_d  = err_q;
        last_d = last_q;
        if (init) begin
            cnt0_d = '0;
            cnt1_d = '0;
            err_d  = 1'b0;
            last_d = 1'b1;
        end else begin
            if (push && !pend_src_q && (cnt0_q != {CW{1'b1}}))
                cnt0_d = cnt0_q + {{(CW-1){1'b0}}, 1'b1};
            if (push && pend_src_q && (cnt1_q != {CW{1'b1}}))
                cnt1_d = cnt1_q + {{(CW-1){1'b0}}, 1'b1};
            if (mismatch) err_d = 1'b1;
            if (D1_rd)      last_d = 1'b1;
            else if (D0_rd) last_d = 1'b0;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        if (mismatch && !init && (state_q != S_ERROR)) begin
            state_d = S_ERROR;
        end else begin
            case (state_q)
                S_IDLE:   if (!D0_empty || !D1_empty) state_d = S_ACTIVE;
                S_ACTIVE: if (D0_empty && D1_empty && !pend_q && (occ_q == 2'd0))
                              state_d = S_IDLE;
                S_ERROR:  if (init) state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= S_IDLE;
            occ_q      <= 2'd0;
            head_dat_q <= '0;
            head_src_q <= 1'b0;
            tail_dat_q <= '0;
            tail_src_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_src_q <= 1'b0;
            last_q     <= 1'b1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            head_dat_q <= head_dat_d;
            head_src_q <= head_src_d;
            tail_dat_q <= tail_dat_d;
            tail_src_q <= tail_src_d;
            pend_q     <= D0_rd || D1_rd;
            pend_src_q <= D1_rd;
            last_q     <= last_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            err_q      <= err_d;
        end
    end

    assign out_data   = head_dat_q;
    assign out_src    = head_src_q;
    assign out_valid  = (occ_q != 2'd0);
    assign count_D0   = cnt0_q;
    assign count_D1   = cnt1_q;
    assign error_dest = err_q;
    assign idle_out   = (state_q == S_IDLE);

endmodule

// File: tb/tb_dest_drain_rr.sv
// Purpose : directed bench for dest_drain_rr with FIFO models and an output scoreboard.
// Latency : FIFO model returns read data one cycle after the sampled read strobe.
// Backpr. : out_ready driven per step; scoreboard compares every accepted output word.
module tb_dest_drain_rr;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       init;
    logic       D0_empty, D1_empty;
    logic [5:0] D0_data_out, D1_data_out;
    logic       out_ready;
    logic       D0_rd, D1_rd;
    logic [5:0] out_data;
    logic       out_valid, out_src;
    logic [7:0] count_D0, count_D1;
    logic       error_dest, idle_out;

    dest_drain_rr #(.BW(6), .CW(8)) dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .D0_empty(D0_empty), .D1_empty(D1_empty),
        .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
        .out_ready(out_ready),
        .D0_rd(D0_rd), .D1_rd(D1_rd),
        .out_data(out_data), .out_valid(out_valid), .out_src(out_src),
        .count_D0(count_D0), .count_D1(count_D1),
        .error_dest(error_dest), .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int failed = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic [6:0] exp_q[$];      // {src, data}
    int         rd_log[$];     // source of each read, in issue order

    int cyc = 0;
    int n_rd, n_vld, first_rd, last_rd, first_vld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        n_rd = 0; n_vld = 0; first_rd = -1; last_rd = -1; first_vld = -1;
        rd_log.delete();
    endtask

    task automatic load(input bit src, input logic [5:0] d, input bit good);
        if (src) q1.push_back(d);
        else     q0.push_back(d);
        if (good) exp_q.push_back({src, d});
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    endtask

    // One clock: sample at negedge, then update FIFO models just after the rising edge.
    task automatic tick();
        logic rd0, rd1;
        logic [6:0] e;
        @(negedge clk);
        rd0 = D0_rd;
        rd1 = D1_rd;
        chk("rd_onehot", {31'b0, rd0 & rd1}, 0);
        chk("rd_nonempty", {30'b0, rd0 & D0_empty, rd1 & D1_empty}, 0);
        if (rd0 || rd1) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            rd_log.push_back(int'(rd1));
        end
        if (out_valid === 1'b1) begin
            n_vld++;
            if (first_vld < 0) first_vld = cyc;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("sb_nonempty", {31'b0, exp_q.size() != 0}, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_word", {25'b0, out_src, out_data}, {25'b0, e});
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rd0 && q0.size() > 0) D0_data_out = q0.pop_front();
        if (rd1 && q1.size() > 0) D1_data_out = q1.pop_front();
        D0_empty = (q0.size() == 0);
        D1_empty = (q1.size() == 0);
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        bit done;
        k = 0;
        done = 0;
        while (!done && k < budget) begin
            tick();
            k++;
            done = (exp_q.size() == 0) && (q0.size() == 0) && (q1.size() == 0) && (idle_out === 1'b1);
        end
        chk(tag, {31'b0, done}, 1);
    endtask

    task automatic pulse_init();
        init = 1'b1;
        tick();
        init = 1'b0;
    endtask

    initial begin
        reset_L = 1'b0; init = 1'b0; out_ready = 1'b1;
        D0_empty = 1'b1; D1_empty = 1'b1;
        D0_data_out = '0; D1_data_out = '0;
        clr_stats();

        // ---- reset state ----
        tick(); tick();
        reset_L = 1'b1;
        tick();
        chk("rst_rd", {30'b0, D0_rd, D1_rd}, 0);
        chk("rst_valid", {31'b0, out_valid}, 0);
        chk("rst_data", {25'b0, out_src, out_data}, 0);
        chk("rst_counts", {16'b0, count_D0, count_D1}, 0);
        chk("rst_err", {31'b0, error_dest}, 0);
        chk("rst_idle", {31'b0, idle_out}, 1);

        // ---- D0 only, 3 words ----
        clr_stats();
        for (int i = 0; i < 3; i++) load(0, 6'(6'h01 + i), 1);
        drain("a_drain", 40);
        chk("a_nrd", n_rd, 3);
        chk("a_rd_consec", last_rd - first_rd, 2);
        chk("a_vld_lat", first_vld - first_rd, 2);
        chk("a_nvld", n_vld, 3);
        chk("a_cnt0", {24'b0, count_D0}, 3);

        // ---- both FIFOs, round-robin ----
        pulse_init();
        chk("init_cnt", {16'b0, count_D0, count_D1}, 0);
        clr_stats();
        for (int i = 0; i < 4; i++) begin
            load(0, 6'(6'h05 + i), 1);
            load(1, 6'(6'h11 + i), 1);
        end
        drain("b_drain", 40);
        chk("b_nrd", n_rd, 8);
        for (int i = 0; i < rd_log.size(); i++) chk("b_rr_order", rd_log[i], i % 2);
        chk("b_cnt0", {24'b0, count_D0}, 4);
        chk("b_cnt1", {24'b0, count_D1}, 4);

        // ---- backpressure ----
        clr_stats();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) load(0, 6'(6'h21 + i), 1);
        for (int i = 0; i < 8; i++) tick();
        chk("c_nrd_stall", n_rd, 2);
        chk("c_valid_hold", {31'b0, out_valid}, 1);
        chk("c_head", {26'b0, out_data}, 6'h21);
        out_ready = 1'b1;
        drain("c_drain", 40);
        chk("c_nrd_total", n_rd, 5);

        // ---- destination mismatch ----
        pulse_init();
        clr_stats();
        load(1, 6'h02, 0);
        begin
            int k;
            k = 0;
            while (error_dest !== 1'b1 && k < 10) begin tick(); k++; end
        end
        chk("d_err_set", {31'b0, error_dest}, 1);
        chk("d_cnt1_kept", {24'b0, count_D1}, 0);
        chk("d_no_out", {31'b0, out_valid}, 0);
        clr_stats();
        load(0, 6'h07, 1);
        load(1, 6'h16, 1);
        for (int i = 0; i < 5; i++) tick();
        chk("d_no_rd_in_err", n_rd, 0);
        chk("d_err_sticky", {31'b0, error_dest}, 1);
        pulse_init();
        chk("d_err_clr", {31'b0, error_dest}, 0);
        chk("d_cnt_clr", {16'b0, count_D0, count_D1}, 0);
        drain("d_drain", 40);
        chk("d_cnt0", {24'b0, count_D0}, 1);
        chk("d_cnt1", {24'b0, count_D1}, 1);

        // ---- counter saturation ----
        pulse_init();
        for (int i = 0; i < 255; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            load(0, {iv[4], 1'b0, iv[3:0]}, 1);
        end
        drain("e_drain255", 700);
        chk("e_cnt255", {24'b0, count_D0}, 255);
        load(0, 6'h0A, 1);
        drain("e_drain256", 40);
        chk("e_cnt_sat", {24'b0, count_D0}, 255);

        $display("%0d/%0d checks passed", passed, passed + failed);
        $finish;
    end

endmodule

// File: doc/dest_drain_rr.md
# dest_drain_rr

Downstream consumer of the D0/D1 destination FIFOs of the PCIe QoS module. It drains both FIFOs with round-robin arbitration and checks each word's destination bit against the FIFO it came from. It merges the words into one ready/valid output stream through a 2-entry output buffer and keeps per-destination word counters for the testbench and the status logic.

## Interface
Parameters:
- BW, 6, word width; bit [BW-2] is the destination bit (0 = D0, 1 = D1).
- CW, 8, width of each word counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- init  in  1  synchronous clear of counters, error state and arbitration pointer.
- D0_empty  in  1  D0 FIFO empty flag.
- D1_empty  in  1  D1 FIFO empty flag.
- D0_data_out  in  BW  D0 FIFO read data, valid the cycle after D0_rd.
- D1_data_out  in  BW  D1 FIFO read data, valid the cycle after D1_rd.
- out_ready  in  1  downstream accepts out_data this cycle.
- D0_rd  out  1  read strobe to D0 FIFO.
- D1_rd  out  1  read strobe to D1 FIFO.
- out_data  out  BW  head word of output buffer.
- out_valid  out  1  output buffer not empty.
- out_src  out  1  source FIFO of out_data (0 = D0, 1 = D1).
- count_D0  out  CW  words accepted from D0, saturating.
- count_D1  out  CW  words accepted from D1, saturating.
- error_dest  out  1  sticky destination-mismatch flag.
- idle_out  out  1  high in IDLE state.

## Operation
- FSM states: IDLE, ACTIVE, ERROR. Reset state is IDLE.
- IDLE -> ACTIVE when either FIFO is non-empty.
- ACTIVE -> IDLE when both FIFOs are empty, no read is in flight and the buffer is empty.
- ACTIVE -> ERROR on a destination mismatch.
- ERROR -> IDLE only on init.
- Read issue: at most one of D0_rd/D1_rd is asserted per cycle, only in IDLE/ACTIVE, and never to an empty FIFO.
- Credit: a read is issued when occ + pend - pop < 2.
  - occ is the buffer occupancy (0..2).
  - pend is the read issued last cycle (0/1).
  - pop is out_valid & out_ready.
- Round-robin: when both FIFOs are non-empty, grant the FIFO not granted last. With one non-empty, grant it. The pointer resets to "last = D1", so D0 wins the first tie.
- Capture: the cycle after a read, the word is checked.
  - If data[BW-2] equals the source index, the word is pushed into the buffer with its src tag and the matching counter increments, saturating at 2^CW-1.
  - Otherwise the word is dropped, no counter changes, error_dest is set and the FSM enters ERROR.
- Buffer: 2-entry FIFO, head drives out_data/out_src. Push and pop in the same cycle are allowed at any occupancy.
- In ERROR: no new reads. An in-flight read is still captured and checked. Already-buffered words keep draining.
- init has priority over counting and over error set in the same cycle:
  - clears counters, error_dest and the RR pointer;
  - moves ERROR -> IDLE;
  - does not flush the buffer or cancel an in-flight read.

## Timing
- Reset values: D0_rd = D1_rd = 0, out_valid = 0, out_data = 0, out_src = 0, counts = 0, error_dest = 0, idle_out = 1.
- D*_rd is combinational from registered state and the empty flags. All other outputs are registered.
- Latency: rd in cycle N → word captured at the end of cycle N+1 → out_valid in cycle N+2.
- Throughput: with out_ready held high, one word per cycle sustained.
- With out_ready low: at most 2 words are buffered, then reads stop. No word is ever lost.
- count_D* and error_dest update on the capture edge, i.e. visible in cycle N+2.
- reset_L low mid-operation clears all state immediately. The in-flight word is discarded.

## Test plan
- Reset, both FIFOs empty → all outputs at reset values, no rd, idle_out = 1.
- D0 holds 3 words with dest bit 0, D1 empty, out_ready = 1:
  - D0_rd for 3 consecutive cycles;
  - out_valid for 3 cycles starting 2 cycles after the first rd;
  - count_D0 = 3, then return to IDLE.
- Both FIFOs hold 4 correct words each, out_ready = 1 → rd alternates D0, D1, D0, … starting with D0; count_D0 = count_D1 = 4; out_src alternates.
- out_ready = 0 with D0 non-empty:
  - exactly 2 reads, then rd stays low and out_valid stays high;
  - after raising out_ready, the remaining words arrive in order with none lost.
- D1 word with dest bit 0:
  - the word is not output;
  - error_dest = 1 and count_D1 is unchanged;
  - no further rd until an init pulse, after which error_dest = 0, counts = 0 and draining resumes.
- count_D0 preset to 255 by 255 reads, then one more D0 read → count_D0 stays 255.
